// File: rtl/comparer_pkg.sv
// Shared result encodings and sizing helpers for the comparer magnitude tree.
package comparer_pkg;

  typedef enum logic [2:0] {
    CMP_EQ = 3'b001,
    CMP_LT = 3'b010,
    CMP_GT = 3'b100
  } cmp_res_e;

  localparam logic [15:0] EQ_CNT_MAX = 16'hFFFF;

  // Leaf count of the reduction tree: next power of two at or above n.
  function automatic int tree_pad(input int n);
    return 1 << $clog2(n);
  endfunction

endpackage

// File: rtl/comparer_slice.sv
// One node of the magnitude-compare tree: merges the gt/lt flags of a high and
// a low group, with the high group deciding whenever it is not equal.
module comparer_slice (
  input  logic gt_hi,
  input  logic lt_hi,
  input  logic gt_lo,
  input  logic lt_lo,
  output logic gt,
  output logic lt
);

  assign gt = gt_hi | (~lt_hi & gt_lo);
  assign lt = lt_hi | (~gt_hi & lt_lo);

endmodule

// File: rtl/comparer.sv
// Magnitude comparer: one-hot combinational result from a slice tree, plus a
// registered copy and a saturating count of equality edges.
module comparer
  import comparer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  output logic [2:0]       f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst_n,
  output logic [2:0]       f_q,
  output logic [15:0]      eq_cnt
);

  localparam int LO_W = WIDTH - 1;
  localparam int PAD  = tree_pad(LO_W);

  // Heap-ordered tree over bits [WIDTH-2:0]; node i has children 2i (high) and 2i+1 (low).
  logic [2*PAD-1:1] node_gt_s;
  logic [2*PAD-1:1] node_lt_s;
  logic             msb_gt_s;
  logic             msb_lt_s;
  logic             gt_s;
  logic             lt_s;
  cmp_res_e         f_s;
  cmp_res_e         f_q_r;
  logic [15:0]      eq_cnt_r;

  generate
    for (genvar k = 0; k < PAD; k++) begin : g_leaf
      localparam int BIT = PAD - 1 - k;
      if (BIT < LO_W) begin : g_bit
        assign node_gt_s[PAD+k] = a[BIT] & ~b[BIT];
        assign node_lt_s[PAD+k] = ~a[BIT] & b[BIT];
      end else begin : g_pad
        assign node_gt_s[PAD+k] = 1'b0;
        assign node_lt_s[PAD+k] = 1'b0;
      end
    end

    for (genvar i = 1; i < PAD; i++) begin : g_node
      comparer_slice u_slice (
        .gt_hi (node_gt_s[2*i]),
        .lt_hi (node_lt_s[2*i]),
        .gt_lo (node_gt_s[2*i+1]),
        .lt_lo (node_lt_s[2*i+1]),
        .gt    (node_gt_s[i]),
        .lt    (node_lt_s[i])
      );
    end
  endgenerate

  // A set sign bit means the smaller value, so signed mode swaps the MSB roles.
  assign msb_gt_s = SIGNED_CMP ? (~a[WIDTH-1] & b[WIDTH-1]) : (a[WIDTH-1] & ~b[WIDTH-1]);
  assign msb_lt_s = SIGNED_CMP ? (a[WIDTH-1] & ~b[WIDTH-1]) : (~a[WIDTH-1] & b[WIDTH-1]);

  comparer_slice u_top (
    .gt_hi (msb_gt_s),
    .lt_hi (msb_lt_s),
    .gt_lo (node_gt_s[1]),
    .lt_lo (node_lt_s[1]),
    .gt    (gt_s),
    .lt    (lt_s)
  );

  // Encode the tree flags into the one-hot result.
  always_comb begin
    f_s = CMP_EQ;
    if (gt_s) begin
      f_s = CMP_GT;
    end else if (lt_s) begin
      f_s = CMP_LT;
    end else begin
      f_s = CMP_EQ;
    end
  end

  assign f = f_s;

  // Registered result and saturating equality counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q_r    <= CMP_EQ;
      eq_cnt_r <= 16'd0;
    end else begin
      f_q_r <= f_s;
      if ((f_s == CMP_EQ) && (eq_cnt_r != EQ_CNT_MAX)) begin
        eq_cnt_r <= eq_cnt_r + 16'd1;
      end else begin
        eq_cnt_r <= eq_cnt_r;
      end
    end
  end

  assign f_q    = f_q_r;
  assign eq_cnt = eq_cnt_r;

endmodule

// File: tb/tb_comparer.sv
// Bench for comparer: unsigned and signed instances driven in parallel,
// vector table with a scoreboard for the registered outputs, then a full sweep.
module tb_comparer;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  f_u, f_s, f_q_u, f_q_s;
  logic [15:0] eq_cnt_u, eq_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_m    = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] fu;
    logic [2:0] fs;
  } vec_t;

  typedef struct {
    logic [2:0] fu;
    logic [2:0] fs;
  } exp_t;

  vec_t vecs[14];
  exp_t sb_q[$];

  comparer #(.WIDTH(8), .SIGNED_CMP(1'b0)) u_uns (
    .f(f_u), .a(a), .b(b), .clk(clk), .rst_n(rst_n), .f_q(f_q_u), .eq_cnt(eq_cnt_u)
  );

  comparer #(.WIDTH(8), .SIGNED_CMP(1'b1)) u_sgn (
    .f(f_s), .a(a), .b(b), .clk(clk), .rst_n(rst_n), .f_q(f_q_s), .eq_cnt(eq_cnt_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (a=%0h b=%0h t=%0t)", name, act, exp, a, b, $time);
    end
  endtask

  // Called at a negedge; drives operands, checks f, then checks registered outputs after the edge.
  task automatic apply(input logic [7:0] va, input logic [7:0] vb,
                       input logic [2:0] efu, input logic [2:0] efs);
    exp_t e;
    a = va;
    b = vb;
    #1;
    chk("f_unsigned", {29'd0, f_u}, {29'd0, efu});
    chk("f_signed", {29'd0, f_s}, {29'd0, efs});
    e.fu = efu;
    e.fs = efs;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      if (e.fu == EQ && cnt_m < 65535) cnt_m++;
      chk("f_q_unsigned", {29'd0, f_q_u}, {29'd0, e.fu});
      chk("f_q_signed", {29'd0, f_q_s}, {29'd0, e.fs});
      chk("eq_cnt_unsigned", {16'd0, eq_cnt_u}, cnt_m);
      chk("eq_cnt_signed", {16'd0, eq_cnt_s}, cnt_m);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] ref_u, ref_s;

    vecs[0]  = '{8'h00, 8'h00, EQ, EQ};
    vecs[1]  = '{8'hFF, 8'hFF, EQ, EQ};
    vecs[2]  = '{8'h7F, 8'h80, LT, GT};
    vecs[3]  = '{8'h80, 8'h7F, GT, LT};
    vecs[4]  = '{8'h01, 8'h00, GT, GT};
    vecs[5]  = '{8'hFF, 8'h00, GT, LT};
    vecs[6]  = '{8'h00, 8'hFF, LT, GT};
    vecs[7]  = '{8'h02, 8'h01, GT, GT};
    vecs[8]  = '{8'h55, 8'hAA, LT, GT};
    vecs[9]  = '{8'hFE, 8'hFF, LT, LT};
    vecs[10] = '{8'h80, 8'h80, EQ, EQ};
    vecs[11] = '{8'h80, 8'h00, GT, LT};
    vecs[12] = '{8'h40, 8'h41, LT, LT};
    vecs[13] = '{8'hC0, 8'h3F, GT, LT};

    a = 8'h00;
    b = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_f_q_unsigned", {29'd0, f_q_u}, {29'd0, EQ});
    chk("reset_f_q_signed", {29'd0, f_q_s}, {29'd0, EQ});
    chk("reset_eq_cnt_unsigned", {16'd0, eq_cnt_u}, 32'd0);
    chk("reset_eq_cnt_signed", {16'd0, eq_cnt_s}, 32'd0);

    // Release, then hold equal operands for five edges.
    @(negedge clk);
    rst_n = 1'b1;
    cnt_m = 0;
    for (int i = 0; i < 5; i++) apply(8'h33, 8'h33, EQ, EQ);
    chk("eq_cnt_after_5", {16'd0, eq_cnt_u}, 32'd5);
    apply(8'h02, 8'h01, GT, GT);
    chk("f_q_gt_after_eq_run", {29'd0, f_q_u}, {29'd0, GT});

    for (int i = 0; i < 14; i++) apply(vecs[i].a, vecs[i].b, vecs[i].fu, vecs[i].fs);

    // Asynchronous reset between edges: registers clear at once, f untouched.
    apply(8'h7F, 8'h80, LT, GT);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_f_q", {29'd0, f_q_u}, {29'd0, EQ});
    chk("midreset_eq_cnt", {16'd0, eq_cnt_u}, 32'd0);
    chk("midreset_f_q_signed", {29'd0, f_q_s}, {29'd0, EQ});
    chk("midreset_f_unsigned", {29'd0, f_u}, {29'd0, LT});
    chk("midreset_f_signed", {29'd0, f_s}, {29'd0, GT});
    cnt_m = 0;
    @(posedge clk);
    #1;
    chk("held_reset_f_q", {29'd0, f_q_u}, {29'd0, EQ});
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h01, 8'h00, GT, GT);
    apply(8'h10, 8'h10, EQ, EQ);

    // Exhaustive sweep against a relational reference.
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 256; ib++) begin
        a = ia[7:0];
        b = ib[7:0];
        #1;
        ref_u = (a > b) ? GT : ((a < b) ? LT : EQ);
        ref_s = ($signed(a) > $signed(b)) ? GT : (($signed(a) < $signed(b)) ? LT : EQ);
        chk("sweep_unsigned", {29'd0, f_u}, {29'd0, ref_u});
        chk("sweep_signed", {29'd0, f_s}, {29'd0, ref_s});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comparer.md
COMPARER -- requirements
Module: comparer

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..64.
REQ-002 Parameter SIGNED_CMP, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 clk  input  1  single clock, rising edge; used only by registered outputs.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 f  output  3  combinational result, one-hot: bit2 = a>b, bit1 = a<b, bit0 = a==b.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 f_q  output  3  f registered on clk.
REQ-009 eq_cnt  output  16  count of clock edges on which f indicated equality.
REQ-010 Positional declaration order SHALL be f, a, b, clk, rst_n, f_q, eq_cnt, so a three-port positional instance (f, a, b) is legal and fully functional for f.

Function
REQ-011 f SHALL be purely combinational from a and b, with no dependence on clk or rst_n.
REQ-012 Exactly one bit of f SHALL be set for any known a, b: 3'b100, 3'b010 or 3'b001.
REQ-013 With SIGNED_CMP=0, operands SHALL be unsigned: 0x7F vs 0x80 gives f=3'b010.
REQ-014 With SIGNED_CMP=1, MSB is sign: 0x7F vs 0x80 gives f=3'b100; 0xFF vs 0x00 gives f=3'b010.
REQ-015 Equality SHALL hold for identical bit patterns regardless of SIGNED_CMP, including 0x00/0x00 and 0xFF/0xFF.
REQ-016 f SHALL settle within one combinational path; no latency cycles.
REQ-017 f_q SHALL equal the value of f sampled at the previous rising clk edge (one-cycle latency).
REQ-018 eq_cnt SHALL increment by 1 on each rising edge where f[0]=1, saturating at 16'hFFFF (no wrap).
REQ-019 Operand changes between edges SHALL NOT affect f_q or eq_cnt until the next edge.

Reset
REQ-020 rst_n low SHALL immediately force f_q=3'b001 and eq_cnt=0, independent of clk.
REQ-021 rst_n assertion mid-operation SHALL NOT affect f.
REQ-022 Release of rst_n SHALL take effect at the first rising edge after deassertion; no sync stage inside the block.

Structure
REQ-023 Comparison SHALL be built as a tree of bit-slice instances of sub-module comparer_slice (inputs: per-bit or per-group gt/lt from two halves; output: combined gt/lt, MSB half dominant).
REQ-024 Signed mode SHALL be realised by swapping the MSB gt/lt roles in the top stage, not by a separate datapath.
REQ-025 Result encodings (GT=3'b100, LT=3'b010, EQ=3'b001) SHALL live in a shared package, comparer_pkg.
REQ-026 No latches; all sequential logic SHALL use the clk/rst_n pair only.

Verification
REQ-027 a=0x00, b=0x00 -> f=3'b001 after settle.
REQ-028 a=0xFF, b=0xFF -> f=3'b001; a=0x7F, b=0x80 (SIGNED_CMP=0) -> f=3'b010.
REQ-029 a=0x01, b=0x00 -> f=3'b100; with SIGNED_CMP=1, a=0x80, b=0x7F -> f=3'b010.
REQ-030 Hold a=b for 5 clk edges after reset release -> eq_cnt=5; f_q=3'b001; then a=0x02, b=0x01 -> f_q=3'b100 one edge later.
REQ-031 Assert rst_n low between edges -> f_q=3'b001 and eq_cnt=0 immediately, f unchanged.
REQ-032 Exhaustive 8-bit sweep, both SIGNED_CMP values -> f matches reference relational compare and is one-hot for all 65536 pairs.
